// File: rtl/ifu_fetchq.sv
// ifu_fetchq - decoupled instruction-fetch front end between pcu and idu.
//
// Issues in-order fetch requests over a valid/ready channel, buffers the
// returned words in a DEPTH-entry queue and presents them to idu with
// valid/ready flow control. A redirect from pcu flushes the queue and
// squashes responses still in flight.
//
// Ports:
//   i_clk, i_rst                 clock, synchronous active-high reset
//   i_redir_valid, i_redir_pc    redirect strobe and target (bits [1:0] ignored)
//   o_mem_req_valid/_addr        fetch request, i_mem_req_ready accepts it
//   i_mem_rsp_valid/_data/_err   in-order fetch response, always accepted
//   o_ins_valid/o_ins/_pc/_err   head instruction toward idu, i_ins_ready consumes
//
// Optional feature: define FETCHQ_BYPASS_EN to forward a live response to idu
// combinationally when the queue is empty (zero-latency path).
module ifu_fetchq #(
    parameter int unsigned          DEPTH     = 4,
    parameter int unsigned          CPU_WIDTH = 64,
    parameter int unsigned          INS_WIDTH = 32,
    parameter logic [CPU_WIDTH-1:0] RESET_PC  = 64'h8000_0000
) (
    input  logic                 i_clk,
    input  logic                 i_rst,
    input  logic                 i_redir_valid,
    input  logic [CPU_WIDTH-1:0] i_redir_pc,
    output logic                 o_mem_req_valid,
    input  logic                 i_mem_req_ready,
    output logic [CPU_WIDTH-1:0] o_mem_req_addr,
    input  logic                 i_mem_rsp_valid,
    input  logic [INS_WIDTH-1:0] i_mem_rsp_data,
    input  logic                 i_mem_rsp_err,
    output logic                 o_ins_valid,
    input  logic                 i_ins_ready,
    output logic [INS_WIDTH-1:0] o_ins,
    output logic [CPU_WIDTH-1:0] o_ins_pc,
    output logic                 o_ins_err
);

    localparam int unsigned PTR_W = $clog2(DEPTH);
    localparam int unsigned CNT_W = PTR_W + 1;
    localparam int unsigned SUM_W = CNT_W + 1;
    localparam logic [CPU_WIDTH-1:0] PC_STEP  = CPU_WIDTH'(4);
    localparam logic [CPU_WIDTH-1:0] PC_ALIGN = ~CPU_WIDTH'(3);

    typedef struct packed {
        logic [INS_WIDTH-1:0] ins;
        logic [CPU_WIDTH-1:0] pc;
        logic                 err;
    } entry_t;

    entry_t               mem_q [DEPTH];
    entry_t               head_q, head_n, rsp_entry;
    logic [PTR_W-1:0]     rd_ptr, rd_ptr_n, wr_ptr, wr_ptr_n;
    logic [CNT_W-1:0]     count, count_n, rem;
    logic [CNT_W-1:0]     inflight, inflight_n, drop, drop_n;
    logic [CPU_WIDTH-1:0] fpc, fpc_n, rpc, rpc_n, req_addr_n, redir_tgt;
    logic                 stale, stale_n, q_valid, q_valid_n, req_valid_n;
    logic                 req_fire, req_pend, rsp_live, byp, enq, deq_q;
    logic [SUM_W-1:0]     live_n;

    assign redir_tgt = i_redir_pc & PC_ALIGN;
    assign req_fire  = o_mem_req_valid & i_mem_req_ready;
    assign req_pend  = o_mem_req_valid & ~i_mem_req_ready;
    // A response is live only when nothing is left to discard and no redirect squashes it now.
    assign rsp_live  = i_mem_rsp_valid & (drop == '0) & ~i_redir_valid;
    assign deq_q     = q_valid & i_ins_ready;
    assign rsp_entry = '{ins: i_mem_rsp_data, pc: rpc, err: i_mem_rsp_err};

`ifdef FETCHQ_BYPASS_EN
    assign byp         = rsp_live & (count == '0);
    assign o_ins_valid = q_valid | byp;
    assign o_ins       = byp ? i_mem_rsp_data : head_q.ins;
    assign o_ins_pc    = byp ? rpc            : head_q.pc;
    assign o_ins_err   = byp ? i_mem_rsp_err  : head_q.err;
`else
    assign byp         = 1'b0;
    assign o_ins_valid = q_valid;
    assign o_ins       = head_q.ins;
    assign o_ins_pc    = head_q.pc;
    assign o_ins_err   = head_q.err;
`endif

    // A bypassed word that idu takes immediately never enters the queue.
    assign enq = rsp_live & ~(byp & i_ins_ready);

    // Next-state for counters, pointers, PCs, head register and request channel.
    always_comb begin
        inflight_n = inflight + CNT_W'(req_fire) - CNT_W'(i_mem_rsp_valid);
        drop_n     = drop;
        stale_n    = stale;
        fpc_n      = fpc;
        rpc_n      = rpc;
        count_n    = count + CNT_W'(enq) - CNT_W'(deq_q);
        rd_ptr_n   = rd_ptr + PTR_W'(deq_q);
        wr_ptr_n   = wr_ptr + PTR_W'(enq);
        rem        = count - CNT_W'(deq_q);
        head_n     = head_q;

        // Head shows the oldest surviving entry; it holds when the queue drains.
        if (rem != '0) begin
            head_n = mem_q[rd_ptr_n];
        end else if (enq) begin
            head_n = rsp_entry;
        end

        // A stale request was already replaced by the redirect target in fpc.
        if (req_fire) begin
            if (stale) begin
                drop_n  = drop_n + CNT_W'(1);
                stale_n = 1'b0;
            end else begin
                fpc_n = fpc + PC_STEP;
            end
        end
        if (i_mem_rsp_valid && (drop != '0)) begin
            drop_n = drop_n - CNT_W'(1);
        end
        if (rsp_live) begin
            rpc_n = rpc + PC_STEP;
        end

        // Redirect: everything in flight after this cycle becomes discard credit.
        if (i_redir_valid) begin
            count_n  = '0;
            rd_ptr_n = '0;
            wr_ptr_n = '0;
            head_n   = head_q;
            fpc_n    = redir_tgt;
            rpc_n    = redir_tgt;
            drop_n   = inflight_n;
            stale_n  = req_pend;
        end

        q_valid_n = (count_n != '0);

        // Raise only with credit for one more live word; the inflight guard keeps
        // the counter from wrapping when many squashed fetches are outstanding.
        live_n      = SUM_W'(count_n) + SUM_W'(inflight_n) - SUM_W'(drop_n);
        req_valid_n = req_pend |
                      ((live_n < SUM_W'(DEPTH)) & (inflight_n != {CNT_W{1'b1}}));
        req_addr_n  = req_pend ? o_mem_req_addr : fpc_n;
    end

    // Control and output registers.
    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            fpc             <= RESET_PC;
            rpc             <= RESET_PC;
            inflight        <= '0;
            drop            <= '0;
            stale           <= 1'b0;
            count           <= '0;
            rd_ptr          <= '0;
            wr_ptr          <= '0;
            q_valid         <= 1'b0;
            head_q          <= '0;
            o_mem_req_valid <= 1'b0;
            o_mem_req_addr  <= RESET_PC;
        end else begin
            fpc             <= fpc_n;
            rpc             <= rpc_n;
            inflight        <= inflight_n;
            drop            <= drop_n;
            stale           <= stale_n;
            count           <= count_n;
            rd_ptr          <= rd_ptr_n;
            wr_ptr          <= wr_ptr_n;
            q_valid         <= q_valid_n;
            head_q          <= head_n;
            o_mem_req_valid <= req_valid_n;
            o_mem_req_addr  <= req_addr_n;
        end
    end

    // Queue storage; contents are meaningless outside [rd_ptr, rd_ptr+count).
    always_ff @(posedge i_clk) begin
        if (enq) begin
            mem_q[wr_ptr] <= rsp_entry;
        end
    end

endmodule

// File: tb/tb_ifu_fetchq.sv
// tb_ifu_fetchq - randomized scoreboard bench for ifu_fetchq.
// A driver process plays pcu, memory and idu; a monitor on the falling edge
// pops the expected instruction stream and compares it with the DUT.
module tb_ifu_fetchq;

    localparam int unsigned DEPTH    = 4;
    localparam logic [63:0] RESET_PC = 64'h8000_0000;

    logic        i_clk;
    logic        i_rst;
    logic        i_redir_valid;
    logic [63:0] i_redir_pc;
    logic        o_mem_req_valid;
    logic        i_mem_req_ready;
    logic [63:0] o_mem_req_addr;
    logic        i_mem_rsp_valid;
    logic [31:0] i_mem_rsp_data;
    logic        i_mem_rsp_err;
    logic        o_ins_valid;
    logic        i_ins_ready;
    logic [31:0] o_ins;
    logic [63:0] o_ins_pc;
    logic        o_ins_err;

    ifu_fetchq #(.DEPTH(DEPTH), .RESET_PC(RESET_PC)) dut (
        .i_clk           (i_clk),
        .i_rst           (i_rst),
        .i_redir_valid   (i_redir_valid),
        .i_redir_pc      (i_redir_pc),
        .o_mem_req_valid (o_mem_req_valid),
        .i_mem_req_ready (i_mem_req_ready),
        .o_mem_req_addr  (o_mem_req_addr),
        .i_mem_rsp_valid (i_mem_rsp_valid),
        .i_mem_rsp_data  (i_mem_rsp_data),
        .i_mem_rsp_err   (i_mem_rsp_err),
        .o_ins_valid     (o_ins_valid),
        .i_ins_ready     (i_ins_ready),
        .o_ins           (o_ins),
        .o_ins_pc        (o_ins_pc),
        .o_ins_err       (o_ins_err)
    );

    typedef struct {
        logic [63:0] addr;
        int          tag;
        int          due;
    } mreq_t;

    typedef struct {
        logic [63:0] pc;
        logic [31:0] ins;
        logic        err;
        int          cyc;
    } exp_t;

    mreq_t       mq[$];
    exp_t        sb[$];
    int          n_checks = 0;
    int          n_fail   = 0;
    int          n_deq    = 0;
    int          cyc      = 0;
    int          epoch    = 0;
    int          raise_tag = 0;
    bit          mon_en   = 0;
    bit          prev_pend = 0;
    bit          expect_raise = 0;
    logic [63:0] prev_addr = '0;
    logic [63:0] next_pc = RESET_PC;

    initial begin
        i_clk = 1'b0;
        forever #5 i_clk = ~i_clk;
    end

    always @(posedge i_clk) cyc <= cyc + 1;

    // Memory contents: a fixed scramble of the address; fault on every word at offset 8 mod 64.
    function automatic logic [31:0] f_data(input logic [63:0] a);
        return a[31:0] ^ 32'h5A5A_C3C3 ^ {a[15:0], a[31:16]};
    endfunction

    function automatic logic f_err(input logic [63:0] a);
        return a[5:2] == 4'd2;
    endfunction

    task automatic check(input string nm, input logic [63:0] act, input logic [63:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h, want %h (cycle %0d)", nm, act, exp, cyc);
        end
    endtask

    // Monitor: idu side. Expected stream is whatever the scoreboard holds from earlier cycles.
    always @(negedge i_clk) begin : monitor
        logic exp_v;
        if (mon_en) begin
            exp_v = (sb.size() > 0) && (sb[0].cyc < cyc);
            if (!i_rst) begin
                check("ins_valid", 64'(o_ins_valid), 64'(exp_v));
                if (o_ins_valid && exp_v) begin
                    check("ins_pc", o_ins_pc, sb[0].pc);
                    check("ins_word", 64'(o_ins), 64'(sb[0].ins));
                    check("ins_err", 64'(o_ins_err), 64'(sb[0].err));
                    if (i_ins_ready) begin
                        void'(sb.pop_front());
                        n_deq++;
                    end
                end
            end
            if (i_redir_valid || i_rst) sb.delete();
        end
    end

    // One driver cycle: memory, pcu and idu stimulus plus request-channel checks.
    task automatic step(input int p_rdy, input int p_ins, input int p_redir, input int max_lat);
        bit          redir, rdy;
        logic [63:0] tgt;
        mreq_t       m;
        int          live, due;

        if (expect_raise) begin
            check("req_valid_after_reset", 64'(o_mem_req_valid), 64'd1);
            check("req_addr_after_reset", o_mem_req_addr, RESET_PC);
            expect_raise = 0;
        end
        if (prev_pend) begin
            check("req_hold_valid", 64'(o_mem_req_valid), 64'd1);
            check("req_hold_addr", o_mem_req_addr, prev_addr);
        end
        if (o_mem_req_valid && !prev_pend) raise_tag = epoch;

        redir = int'($urandom_range(0, 99)) < p_redir;
        tgt   = 64'h8000_0000 + 64'($urandom_range(0, 32'hFFFF));
        rdy   = int'($urandom_range(0, 99)) < p_rdy;
        i_redir_valid   = redir;
        i_redir_pc      = tgt;
        i_mem_req_ready = rdy;
        i_ins_ready     = int'($urandom_range(0, 99)) < p_ins;
        i_mem_rsp_valid = 1'b0;
        i_mem_rsp_data  = '0;
        i_mem_rsp_err   = 1'b0;

        if (mq.size() > 0 && mq[0].due <= cyc) begin
            m = mq.pop_front();
            i_mem_rsp_valid = 1'b1;
            i_mem_rsp_data  = f_data(m.addr);
            i_mem_rsp_err   = f_err(m.addr);
            // Live only if no redirect happened since the request was raised, including now.
            if (m.tag == epoch && !redir) begin
                check("live_rsp_addr", m.addr, next_pc);
                sb.push_back('{pc: next_pc, ins: f_data(next_pc), err: f_err(next_pc), cyc: cyc});
                next_pc += 64'd4;
            end
        end

        if (o_mem_req_valid && rdy) begin
            if (raise_tag == epoch) begin
                live = 0;
                foreach (mq[i]) if (mq[i].tag == epoch) live++;
                check("credit_limit", 64'(sb.size() + live + 1 <= int'(DEPTH)), 64'd1);
            end
            due = cyc + int'($urandom_range(1, max_lat));
            if (mq.size() > 0 && due <= mq[$].due) due = mq[$].due + 1;
            mq.push_back('{addr: o_mem_req_addr, tag: raise_tag, due: due});
        end

        prev_pend = o_mem_req_valid && !rdy;
        prev_addr = o_mem_req_addr;
        if (redir) begin
            epoch++;
            next_pc = tgt & ~64'h3;
        end
    endtask

    task automatic run_phase(input int n, input int p_rdy, input int p_ins,
                             input int p_redir, input int max_lat);
        for (int c = 0; c < n; c++) begin
            @(posedge i_clk); #1;
            step(p_rdy, p_ins, p_redir, max_lat);
        end
    endtask

    task automatic do_reset(input int ncyc);
        @(posedge i_clk); #1;
        i_rst           = 1'b1;
        i_redir_valid   = 1'b0;
        i_mem_req_ready = 1'b0;
        i_mem_rsp_valid = 1'b0;
        i_ins_ready     = 1'b0;
        mq.delete();
        epoch++;
        prev_pend = 0;
        next_pc   = RESET_PC;
        repeat (ncyc - 1) begin
            @(posedge i_clk); #1;
        end
        @(posedge i_clk); #1;
        i_rst = 1'b0;
        check("rst_req_valid", 64'(o_mem_req_valid), 64'd0);
        check("rst_req_addr", o_mem_req_addr, RESET_PC);
        check("rst_ins_valid", 64'(o_ins_valid), 64'd0);
        check("rst_ins", 64'(o_ins), 64'd0);
        check("rst_ins_pc", o_ins_pc, 64'd0);
        check("rst_ins_err", 64'(o_ins_err), 64'd0);
        expect_raise = 1;
    endtask

    initial begin
        int d0;
        i_rst           = 1'b1;
        i_redir_valid   = 1'b0;
        i_redir_pc      = '0;
        i_mem_req_ready = 1'b0;
        i_mem_rsp_valid = 1'b0;
        i_mem_rsp_data  = '0;
        i_mem_rsp_err   = 1'b0;
        i_ins_ready     = 1'b0;

        do_reset(2);
        mon_en = 1;

        // Free-flowing stream: one instruction per cycle once warmed up.
        run_phase(20, 100, 100, 0, 1);
        d0 = n_deq;
        run_phase(180, 100, 100, 0, 1);
        check("stream_rate", 64'(n_deq - d0), 64'd180);

        // idu stalled: queue fills to DEPTH and fetching stops.
        run_phase(40, 100, 0, 0, 1);
        check("full_req_valid", 64'(o_mem_req_valid), 64'd0);
        check("full_ins_valid", 64'(o_ins_valid), 64'd1);
        check("full_queue_count", 64'(sb.size()), 64'(DEPTH));
        check("full_no_outstanding", 64'(mq.size()), 64'd0);

        // Backpressure everywhere, redirects and variable latency.
        run_phase(400, 60, 70, 5, 4);
        do_reset(1);
        run_phase(400, 30, 40, 10, 6);
        run_phase(300, 90, 90, 2, 2);

        check("progress", 64'(n_deq > 400), 64'd1);
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/ifu_fetchq.md
# ifu_fetchq

Decoupled instruction-fetch front end between the PC unit and the decoder. It issues in-order instruction fetch requests to instruction memory over a valid/ready request channel. It buffers the returned words in a DEPTH-entry queue and presents them to `idu` with valid/ready flow control. Branch/jump redirects from `pcu` flush the queue and squash responses still in flight.

## Interface
Parameters:
- `DEPTH`, 4: queue entries and maximum live outstanding fetches; power of 2, ≥2
- `RESET_PC`, 64'h8000_0000: first fetch address after reset
- Widths come from `config.sv`: `CPU_WIDTH` = 64, `INS_WIDTH` = 32.

Ports:
- `i_clk`  in  1  clock; all state updates on the rising edge
- `i_rst`  in  1  reset, synchronous, active-high
- `i_redir_valid`  in  1  redirect strobe from `pcu`
- `i_redir_pc`  in  CPU_WIDTH  redirect target; bits [1:0] are ignored and treated as 0
- `o_mem_req_valid`  out  1  fetch request valid
- `i_mem_req_ready`  in  1  memory accepts the request
- `o_mem_req_addr`  out  CPU_WIDTH  fetch address, 4-byte aligned
- `i_mem_rsp_valid`  in  1  response valid; responses are in order and always accepted
- `i_mem_rsp_data`  in  INS_WIDTH  instruction word
- `i_mem_rsp_err`  in  1  access fault for this response
- `o_ins_valid`  out  1  head entry valid toward `idu`
- `i_ins_ready`  in  1  `idu` consumes the head entry
- `o_ins`  out  INS_WIDTH  instruction word
- `o_ins_pc`  out  CPU_WIDTH  PC of `o_ins`
- `o_ins_err`  out  1  fetch fault flag of `o_ins`

## Operation
State:
- `fpc`: next fetch address
- `rpc`: PC of the next live response
- `inflight`: accepted requests with no response yet
- `drop`: responses still to discard
- `stale`: the pending request predates a redirect
- Queue: DEPTH entries, each holding {ins, pc, err}

Counters are clog2(DEPTH)+1 bits wide.

Requests:
- `o_mem_req_valid` rises only when (count + inflight − drop) < DEPTH.
- Once raised, `o_mem_req_valid` and `o_mem_req_addr` hold stable until accepted, even across a redirect.
- A request fires on valid&ready: `fpc` += 4, `inflight` += 1.
- If the firing request has `stale` set, `drop` also += 1 and `stale` clears.

Responses:
- A response arrives with `inflight` −= 1.
- If `drop` > 0 or `i_redir_valid` is high that cycle, the response is discarded (`drop` −= 1 when `drop` > 0).
- Otherwise it is enqueued as {data, `rpc`, err} and `rpc` += 4.
- An error response is enqueued normally; fetching continues.

Dequeue:
- A dequeue happens on `o_ins_valid` & `i_ins_ready`.
- `o_ins`/`o_ins_pc`/`o_ins_err` always show the head entry; they hold when the queue is empty.

Redirect (highest priority):
- Queue is emptied. A dequeue in the same cycle still counts as consumed.
- `fpc` and `rpc` load `{i_redir_pc[CPU_WIDTH-1:2], 2'b00}`.
- `drop` loads the post-cycle value of `inflight`.
- `stale` is set if a request is pending and not firing this cycle.
- Back-to-back redirects: the last one wins; `drop` accumulates correctly.

Reset:
- `fpc` = `rpc` = RESET_PC
- `inflight` = `drop` = 0, `stale` = 0, queue empty
- `o_mem_req_valid` = 0, `o_ins_valid` = 0, `o_ins` = 0, `o_ins_pc` = 0, `o_ins_err` = 0
- `o_mem_req_addr` = RESET_PC
- Reset asserted mid-operation abandons all state; responses to pre-reset requests are the memory's responsibility and must not arrive after reset.

## Timing
- Cycle after `i_rst` deasserts: `o_mem_req_valid` = 1, `o_mem_req_addr` = RESET_PC.
- With memory always ready, one request issues per cycle until credit is exhausted.
- Response in cycle N → `o_ins_valid` in cycle N+1 (registered queue).
- Redirect in cycle N:
  - `o_ins_valid` = 0 in N+1.
  - The first new request is raised in N+1 if nothing is pending; otherwise the cycle after the stale request fires.
- Full queue with `i_ins_ready` = 0: no request is raised; credit guarantees no overflow.
- Simultaneous enqueue and dequeue at count = DEPTH−1 is legal; count stays the same.

## Configuration
- `FETCHQ_BYPASS_EN` defined:
  - When the queue is empty, `drop` = 0 and there is no redirect, a live response drives `o_ins_valid`/`o_ins`/`o_ins_pc`/`o_ins_err` combinationally in the same cycle (zero latency).
  - If `i_ins_ready` = 1 the word is not enqueued; otherwise it is enqueued normally.
- Undefined: all outputs toward `idu` come from queue registers; latency is 1 cycle.

## Test plan
- Reset release, memory always ready, 1-cycle response, `i_ins_ready` = 1 → `o_ins_pc` sequence 8000_0000, 8000_0004, 8000_0008…, one per cycle; first valid at cycle 3 (2 with bypass).
- `i_ins_ready` = 0 with DEPTH = 4 → exactly 4 requests accepted, queue holds 4 entries, `o_mem_req_valid` stays 0 until the first dequeue.
- Redirect to 8000_0102 with 3 requests in flight → those 3 responses are discarded; next `o_ins_pc` is 8000_0100.
- Redirect while a request to 8000_0010 is pending and the memory is not ready → address held until accepted, its response dropped, then a fetch is issued at the target.
- `i_mem_rsp_err` = 1 on the word for 8000_0008 → delivered with `o_ins_err` = 1; 8000_000C follows with err = 0.
- `i_rst` asserted for 1 cycle mid-stream → all outputs return to reset values next cycle; the fetch restarts at RESET_PC.
